// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// The 128-bit state is loaded into a working register. One 32-bit column is
// transformed per cycle and written back in place. The result is then held
// behind a valid/ready handshake.
module mix_columns_iter #(
    parameter int NB_BYTE       = 8,
    parameter int N_BYTES_STATE = 16
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic                               i_valid,
    input  logic [NB_BYTE*N_BYTES_STATE-1:0]   i_state,
    input  logic                               i_inverse,
    output logic                               o_ready,
    input  logic                               i_ready,
    output logic                               o_valid,
    output logic [NB_BYTE*N_BYTES_STATE-1:0]   o_state
);

    localparam int W = NB_BYTE * N_BYTES_STATE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8), reducing modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using conditional shift-and-reduce stages.
    // All MixColumns coefficients fit in 4 bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Transform one column. Row i uses coefficient k[(j - i) mod 4] on byte j.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [3:0]  k [4];
        logic [7:0]  r;
        logic [1:0]  idx;
        logic [31:0] res;
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - i);
                r   = r ^ gf_mul(a[j], k[idx]);
            end
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic          inv_q, inv_d;
    logic [W-1:0]  work_q, work_d;
    logic [31:0]   col_in;
    logic [31:0]   col_out;
    logic          accept;

    assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign o_valid = (state_q == DONE);
    assign o_state = work_q;
    assign accept  = i_valid && o_ready;

    // Select the current column and compute its transform.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        col_in = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) col_in = work_q[W-1-32*c -: 32];
        end
        col_out = mix_col(col_in, inv_q);
    end

    // Next-state logic: handshake, column sequencing and in-place write-back.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        inv_d   = inv_q;
        work_d  = work_q;
        unique case (state_q)
            PROC: begin
                for (int c = 0; c < 4; c++) begin
                    if (col_q == 2'(c)) work_d[W-1-32*c -: 32] = col_out;
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            IDLE: ;
            default: state_d = IDLE;
        endcase
        // Acceptance overrides the defaults above, including the DONE->IDLE exit.
        // This lets a transfer out and a new load share one edge.
        if (accept) begin
            work_d  = i_state;
            inv_d   = i_inverse;
            col_d   = 2'd0;
            state_d = PROC;
        end
    end

    // State registers. The working register is reset so o_state reads 0 after reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            inv_q   <= 1'b0;
            work_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            state_q <= state_d;
            col_q   <= col_d;
            inv_q   <= inv_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8, GF(2^8) element width; only 8 is supported.
REQ-002 SHALL have parameter N_BYTES_STATE, default 16, AES state size in bytes; only 16 is supported.
REQ-003 SHALL have port i_clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1, upstream offers i_state/i_inverse this cycle.
REQ-006 SHALL have port i_state, input, NB_BYTE*N_BYTES_STATE (128), AES state; byte 0 at bits [127:120], column c = bytes 4c..4c+3.
REQ-007 SHALL have port i_inverse, input, 1, 0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port o_ready, output, 1, block can accept a state this cycle.
REQ-009 SHALL have port i_ready, input, 1, downstream accepts o_state this cycle.
REQ-010 SHALL have port o_valid, output, 1, o_state holds a complete result.
REQ-011 SHALL have port o_state, output, 128, transformed state, same byte order as i_state.

Function
REQ-012 SHALL implement FSM states IDLE, PROC, DONE.
REQ-013 SHALL accept an input when i_valid && o_ready at a rising edge: load i_state into the working register, latch i_inverse, clear the column counter to 0, and go to PROC.
REQ-014 SHALL drive o_ready = (state==IDLE) || (state==DONE && i_ready).
REQ-015 SHALL ignore i_valid, i_state and i_inverse while o_ready is 0; no sampling, no error.
REQ-016 SHALL, in PROC, transform exactly one 32-bit column per cycle, selected by a 2-bit column counter, and write the result back in place in the working register.
REQ-017 SHALL, after writing column 3, go to DONE; column counter wraps 3->0.
REQ-018 SHALL assert o_valid one rising edge after the last column write: accept at edge k gives o_valid high after edge k+4.
REQ-019 SHALL keep o_valid high and o_state stable in DONE until i_ready is sampled high.
REQ-020 SHALL, in DONE with i_ready high and i_valid low, go to IDLE and deassert o_valid.
REQ-021 SHALL, in DONE with i_ready high and i_valid high, complete the output transfer and accept the new input on the same edge, going directly to PROC; sustained throughput is one state per 5 cycles.
REQ-022 SHALL compute the forward column {a0..a3} -> r0=02a0^03a1^a2^a3, r1=a0^02a1^03a2^a3, r2=a0^a1^02a2^03a3, r3=03a0^a1^a2^02a3.
REQ-023 SHALL compute the inverse column with coefficients 0e,0b,0d,09 in the same rotating pattern: r0=0e a0^0b a1^0d a2^09 a3, and so on.
REQ-024 SHALL perform all GF(2^8) products modulo x^8+x^4+x^3+x+1 (0x11B), built from conditional shift-and-reduce-by-0x1B stages only; no lookup tables.
REQ-025 SHALL compute each column within a single cycle; no multicycle paths.
REQ-026 SHALL keep the direction fixed, as latched at acceptance, for all 4 columns of a state.
REQ-027 SHALL drive o_state directly from the working register; its contents are don't-care unless o_valid is 1.

Reset
REQ-028 SHALL, with i_reset_n low, asynchronously force FSM to IDLE, column counter to 0, latched direction to 0, working register (o_state) to 0, and o_valid to 0.
REQ-029 SHALL assert o_ready in the first cycle after reset release.
REQ-030 SHALL, on reset asserted mid-PROC or in DONE, discard the partial or pending result with no output produced.
REQ-031 SHALL resume normal operation on the first rising edge after i_reset_n deasserts.

Verification
REQ-032 SHALL cover: forward, i_state=db135345_f20a225c_01010101_2d26314c, i_ready=1 -> o_valid 4 edges after accept, o_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, o_valid high for exactly one cycle.
REQ-033 SHALL cover: inverse, i_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8 -> o_state=db135345_f20a225c_01010101_2d26314c.
REQ-034 SHALL cover: forward, column d4d4d4d5 in all four columns -> d5d5d7d6 in all four columns; all-c6 state -> unchanged.
REQ-035 SHALL cover: i_ready held low 10 cycles in DONE -> o_valid and o_state stable, o_ready 0, and a new i_valid with changed i_state ignored.
REQ-036 SHALL cover: back-to-back, i_valid held high with i_ready=1 -> accepts every 5 cycles, output order matches input order, and direction alternates correctly per transfer.
REQ-037 SHALL cover: i_reset_n pulsed low after column 1 is written -> o_state=0, o_valid=0, o_ready=1 after release, with no spurious o_valid.
